// File: rtl/pwm_timebase.sv
// Prescaled PWM time base: up, down and up-down counting with shadowed period, prescale and mode, plus one-shot runs.
// Latency: count_val, dir, ovf and unf are registered and change on the clk edge after the tick that causes them.
// Backpressure: none; en low freezes all state and suppresses the ovf/unf pulses.
module pwm_timebase #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic             one_shot,
  input  logic [CNT_W-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [CNT_W-1:0] count_val,
  output logic             dir,
  output logic             ovf,
  output logic             unf,
  output logic             running
);

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UD   = 2'b10;

  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] prescale_sh;
  logic [CNT_W-1:0] period_sh;
  logic [1:0]       mode_sh;

  logic             active;
  logic             psc_wrap;
  logic             tick;

  logic [CNT_W-1:0] cnt_nxt;
  logic             dir_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             upd;

  // The prescaler only advances while enabled and not stopped by a completed one-shot.
  assign active   = en && running;
  assign psc_wrap = (psc_cnt == prescale_sh);
  assign tick     = active && psc_wrap;

  // Next count, direction and boundary events for the current tick; upd marks a period boundary.
  always_comb begin
    cnt_nxt = count_val;
    dir_nxt = dir;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    upd     = 1'b0;
    if (tick) begin
      case (mode_sh)
        MODE_DOWN: begin
          dir_nxt = 1'b0;
          if (count_val == '0) begin
            // Reload from the live period so a rewritten period is picked up at this boundary.
            cnt_nxt = period;
            unf_nxt = 1'b1;
            upd     = 1'b1;
          end else begin
            cnt_nxt = count_val - CNT_W'(1);
          end
        end
        MODE_UD: begin
          if (period_sh == '0) begin
            // Degenerate triangle: every tick is both top and bottom; report it as a bottom.
            cnt_nxt = '0;
            dir_nxt = 1'b1;
            unf_nxt = 1'b1;
            upd     = 1'b1;
          end else if (dir && (count_val == period_sh)) begin
            dir_nxt = 1'b0;
            cnt_nxt = count_val - CNT_W'(1);
            ovf_nxt = 1'b1;
          end else if (!dir && (count_val == '0)) begin
            // Only the bottom turn is a period boundary, keeping the triangle symmetric.
            dir_nxt = 1'b1;
            cnt_nxt = CNT_W'(1);
            unf_nxt = 1'b1;
            upd     = 1'b1;
          end else if (dir) begin
            cnt_nxt = count_val + CNT_W'(1);
          end else begin
            cnt_nxt = count_val - CNT_W'(1);
          end
        end
        default: begin
          // Modes 00 and 11 both count up.
          dir_nxt = 1'b1;
          if (count_val == period_sh) begin
            cnt_nxt = '0;
            ovf_nxt = 1'b1;
            upd     = 1'b1;
          end else begin
            cnt_nxt = count_val + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // State update: count_reset restarts and reloads shadows; otherwise advance on ticks and reload shadows at boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_val   <= '0;
      psc_cnt     <= '0;
      dir         <= 1'b1;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      running     <= 1'b1;
      period_sh   <= '0;
      prescale_sh <= '0;
      mode_sh     <= 2'b00;
    end else if (count_reset) begin
      psc_cnt     <= '0;
      running     <= 1'b1;
      period_sh   <= period;
      prescale_sh <= prescale;
      mode_sh     <= mode;
      count_val   <= (mode == MODE_DOWN) ? period : '0;
      dir         <= (mode != MODE_DOWN);
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else begin
      if (active) begin
        psc_cnt <= psc_wrap ? '0 : psc_cnt + PSC_W'(1);
      end
      count_val <= cnt_nxt;
      dir       <= dir_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
      if (upd) begin
        period_sh   <= period;
        prescale_sh <= prescale;
        mode_sh     <= mode;
      end
      // one_shot is taken live: the first boundary event of a run stops the time base.
      if (one_shot && (ovf_nxt || unf_nxt)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// Self-checking bench for pwm_timebase: expected observations are queued as stimulus is applied.
// Outputs are sampled 1 time unit after each rising clk edge.
// Inputs are driven with blocking assignments between edges.
module tb_pwm_timebase;

  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             count_reset;
  logic [1:0]       mode;
  logic             one_shot;
  logic [CNT_W-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] count_val;
  logic             dir;
  logic             ovf;
  logic             unf;
  logic             running;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             unf;
    logic             dir;
    logic             run;
  } obs_t;

  obs_t exp_q[$];
  obs_t got;
  obs_t e;
  int   total = 0;
  int   bad   = 0;

  pwm_timebase #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_reset (count_reset),
    .mode        (mode),
    .one_shot    (one_shot),
    .period      (period),
    .prescale    (prescale),
    .count_val   (count_val),
    .dir         (dir),
    .ovf         (ovf),
    .unf         (unf),
    .running     (running)
  );

  always #5 clk = ~clk;

  always_comb got = {count_val, ovf, unf, dir, running};

  function automatic obs_t mk(input int c, input logic o, input logic u, input logic d, input logic r);
    obs_t x;
    x.cnt = c[CNT_W-1:0];
    x.ovf = o;
    x.unf = u;
    x.dir = d;
    x.run = r;
    return x;
  endfunction

  function automatic string fmt(input obs_t x);
    return $sformatf("cnt=%0d ovf=%b unf=%b dir=%b run=%b", x.cnt, x.ovf, x.unf, x.dir, x.run);
  endfunction

  // Pulse count_reset for one edge with the given live configuration.
  task automatic restart(input logic [1:0] m, input int p, input int ps, input logic os);
    mode        = m;
    period      = p[CNT_W-1:0];
    prescale    = ps[PSC_W-1:0];
    one_shot    = os;
    count_reset = 1'b1;
    @(posedge clk);
    #1;
    count_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    count_reset = 1'b0;
    mode        = 2'b00;
    one_shot    = 1'b0;
    period      = '0;
    prescale    = '0;
    #12;
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_up();
    restart(2'b00, 3, 0, 1'b0);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    for (int t = 1; t <= 10; t++) exp_q.push_back(mk(t % 4, (t % 4) == 0, 0, 1, 1));
    for (int t = 0; t <= 10; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL up t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_prescale_en();
    int j;
    int ticks;
    restart(2'b00, 2, 2, 1'b0);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL psc start: got %s want %s", fmt(got), fmt(e));
    end
    j = 0;
    for (int c = 1; c <= 25; c++) begin
      en = !(c >= 5 && c <= 9);
      if (en) j++;
      ticks = j / 3;
      exp_q.push_back(mk(ticks % 3, en && (j % 3 == 0) && (ticks % 3 == 0) && ticks > 0, 0, 1, 1));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL psc c=%0d: got %s want %s", c, fmt(got), fmt(e));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_updown();
    int ud_cnt[6];
    int p;
    ud_cnt = '{0, 1, 2, 3, 2, 1};
    restart(2'b10, 3, 0, 1'b0);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    for (int t = 1; t <= 13; t++) begin
      p = t % 6;
      exp_q.push_back(mk(ud_cnt[p], p == 4, (p == 1) && (t > 1), (p >= 1) && (p <= 3), 1));
    end
    for (int t = 0; t <= 13; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL updown t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_down_rewrite();
    int dn[11];
    dn = '{3, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2};
    restart(2'b01, 4, 0, 1'b0);
    exp_q.push_back(mk(4, 0, 0, 0, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL down start: got %s want %s", fmt(got), fmt(e));
    end
    for (int t = 0; t < 11; t++) begin
      if (t == 2) period = 16'd2;
      exp_q.push_back(mk(dn[t], 0, (t == 4) || (t == 7) || (t == 10), 0, 1));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL down t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_one_shot();
    restart(2'b00, 2, 0, 1'b1);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    exp_q.push_back(mk(1, 0, 0, 1, 1));
    exp_q.push_back(mk(2, 0, 0, 1, 1));
    exp_q.push_back(mk(0, 1, 0, 1, 0));
    for (int t = 0; t < 4; t++) exp_q.push_back(mk(0, 0, 0, 1, 0));
    for (int t = 0; t < 8; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL oneshot t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
    restart(2'b00, 2, 0, 1'b1);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    exp_q.push_back(mk(1, 0, 0, 1, 1));
    exp_q.push_back(mk(2, 0, 0, 1, 1));
    for (int t = 0; t < 3; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rearm t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
    one_shot = 1'b0;
  endtask

  task automatic test_reset_collision();
    int cv[8];
    cv = '{0, 1, 1, 0, 0, 1, 1, 0};
    restart(2'b00, 1, 1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      count_reset = (t == 3);
      exp_q.push_back(mk(cv[t], t == 7, 0, 1, 1));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL collide t=%0d: got %s want %s", t, fmt(got), fmt(e));
      end
    end
    count_reset = 1'b0;
  endtask

  task automatic test_async_reset();
    restart(2'b01, 4, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(2, 0, 0, 0, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL pre-rst: got %s want %s", fmt(got), fmt(e));
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async rst: got %s want %s", fmt(got), fmt(e));
    end
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rst held: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up();
    test_prescale_en();
    test_updown();
    test_down_rewrite();
    test_one_shot();
    test_reset_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
- Parametrised successor to the PWM period counter: prescaled time base with selectable up, down and up-down (centre-aligned) counting, plus one-shot operation.
- Period, prescale and mode are buffered through shadow registers so that register writes take effect only at a period boundary.
- Emits single-cycle overflow/underflow events for the compare/PWM output stage.
- Sits between the register file and the PWM compare channels.

Parameters:
- CNT_W, 16: counter and period width in bits.
- PSC_W, 8: prescaler width in bits.

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; when low, all state holds.
- count_reset  input  1  synchronous restart, single-cycle pulse from the register file.
- mode  input  2  counting mode: 00 up, 01 down, 10 up-down, 11 treated as up.
- one_shot  input  1  when 1, the counter stops after the first period boundary.
- period  input  CNT_W  period value, written to the shadow register.
- prescale  input  PSC_W  prescale value; a tick occurs every prescale+1 clk cycles.
- count_val  output  CNT_W  current count.
- dir  output  1  1 = counting up, 0 = counting down.
- ovf  output  1  one-cycle pulse when the top of the count is reached.
- unf  output  1  one-cycle pulse when the bottom of the count is reached.
- running  output  1  0 once a one-shot run has completed.

Behaviour:
- Reset values: count_val=0, psc_cnt=0, dir=1, ovf=0, unf=0, running=1. Shadow registers reset to period_sh=0, prescale_sh=0, mode_sh=00.
- Priority, highest first: rst_n, then count_reset, then tick logic.
- count_reset:
  - psc_cnt <= 0 and running <= 1.
  - Shadow registers load the live period, prescale and mode.
  - count_val <= live period if the live mode is 01, otherwise 0.
  - dir <= 0 for mode 01, otherwise 1.
  - ovf and unf are 0 in that cycle.
- Prescaler:
  - Active only when en && running: psc_cnt increments.
  - When psc_cnt == prescale_sh, psc_cnt wraps to 0 and tick=1 for that cycle.
  - tick is combinational and gated by en && running.
- Update event (a tick at a period boundary, as defined per mode below): period_sh, prescale_sh and mode_sh load the live inputs on the same edge. A mode change therefore takes effect on the following period.
- Mode up (mode_sh = 00 or 11), on tick:
  - If count == period_sh: count <= 0, ovf pulses; this is an update event.
  - Otherwise count <= count + 1.
- Mode down (mode_sh = 01), on tick:
  - If count == 0: count <= period (live value, loaded together with the shadow), unf pulses; this is an update event.
  - Otherwise count <= count - 1.
- Mode up-down (mode_sh = 10), on tick:
  - dir=1 and count == period_sh: dir <= 0, count <= count - 1, ovf pulses.
  - dir=0 and count == 0: dir <= 1, count <= 1, unf pulses; this is an update event (bottom only).
  - Otherwise count steps by ±1 according to dir.
  - period_sh == 0: count holds at 0, dir stays 1, unf pulses on every tick, and every tick is an update event.
- Event timing:
  - ovf and unf are registered and assert in the same cycle that count_val shows the post-boundary value.
  - Pulses last exactly one clk, including when prescale_sh = 0 and ticks occur back to back.
- One-shot (one_shot=1):
  - On the first ovf or unf event, running <= 0 on that edge; count_val takes the boundary value and the pulse is still emitted.
  - Frozen values: up mode 0; down mode the reloaded period; up-down mode the value after the turn.
  - Re-arm only via count_reset. one_shot is sampled live and is not shadowed.
- en low: count_val, psc_cnt, dir and the shadows hold; ovf and unf are 0. Resuming continues from the exact held psc_cnt.
- Live period below the current count (up mode): takes effect only at the update event, so there is no runaway count. With the live period equal to the shadow, behaviour is identical to a direct period.
- Arithmetic: counts are unsigned CNT_W wide with no carries out. The count never exceeds period_sh, provided period is changed only via the shadow path.
- rst_n asserted mid-run: all state returns immediately (asynchronously) to the reset values.

Test Plan:
- Up mode, period=3, prescale=0, en=1 → count_val 0,1,2,3,0,1…; ovf high only in the cycles count_val returns to 0; unf never asserts.
- Up mode, prescale=2, period=2 → each count value held for 3 clk; ovf every 9 clk; toggling en low for 5 clk stretches exactly that period by 5 clk.
- Up-down mode, period=3 → count_val 0,1,2,3,2,1,0,1…; dir falls when count_val shows 2 after 3; ovf at the 3→2 step, unf at the 0→1 step; 6 ticks per cycle.
- Down mode, period=4, with period rewritten to 2 mid-run → counts 4,3,2,1,0, then reloads 2,1,0,2…; unf at each reload; the new period applies only after the boundary.
- One-shot up mode, period=2 → 0,1,2,0, then running=0 with count_val held at 0 and a single ovf; count_reset restarts counting with running=1.
- count_reset asserted in the same cycle as a boundary tick → count_val=0 (up mode), no ovf pulse, psc_cnt=0. rst_n asserted mid-count → all outputs return to the reset values immediately.
